// File: rtl/ifid_stage_pkg.sv
// Shared constants and types for the MiniMIPS32 IF/ID boundary.
// Stall encoding: a set bit means that stage must stop this cycle.
package ifid_stage_pkg;

   localparam logic [31:0] NOP_INST = 32'h0000_0000;
   localparam logic [4:0]  EXC_NONE = 5'h10;
   localparam logic [4:0]  EXC_ADEL = 5'h04;

   localparam logic STOP   = 1'b1;
   localparam logic NOSTOP = 1'b0;

   localparam int STALL_IF = 1;
   localparam int STALL_ID = 2;

   typedef enum logic {
      HB_RUN,
      HB_HELD
   } hold_state_t;

   function automatic logic is_misaligned(input logic [1:0] pc_low);
      return pc_low != 2'b00;
   endfunction

endpackage

// File: rtl/ifid_hold_buf.sv
// Keeps the instruction word that arrived while decode was stalled.
// Without this buffer the word would be lost, because memory read data is only valid for one cycle.
module ifid_hold_buf
   import ifid_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        stall_id,
   input  logic        fetch_pending,
   input  logic [31:0] inst_i,
   output logic [31:0] inst,
   output logic        held
);

   hold_state_t state;
   logic [31:0] hold_inst;

   // A flush abandons the held word. The next instruction must come from a fresh fetch.
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         state     <= HB_RUN;
         hold_inst <= NOP_INST;
      end else begin
         case (state)
            HB_RUN: begin
               if (stall_id == STOP && fetch_pending) begin
                  state     <= HB_HELD;
                  hold_inst <= inst_i;
               end
            end
            HB_HELD: begin
               if (stall_id == NOSTOP)
                  state <= HB_RUN;
            end
            default: state <= HB_RUN;
         endcase
      end
   end

   assign held = (state == HB_HELD);
   assign inst = held ? hold_inst : (fetch_pending ? inst_i : NOP_INST);

endmodule

// File: rtl/ifid_stage.sv
// IF/ID pipeline register: fetch PC/flags, late memory data alignment, bubbles and AdEL tagging.
module ifid_stage
   import ifid_stage_pkg::*;
(
   input  logic        cpu_clk_50M,
   input  logic        cpu_rst_n,
   input  logic [31:0] if_pc,
   input  logic        if_ice,
   input  logic        if_branch_flag,
   input  logic [31:0] inst_i,
   input  logic [3:0]  stall,
   input  logic        flush,
   output logic [31:0] id_pc,
   output logic [31:0] id_inst,
   output logic        id_valid,
   output logic        id_in_delay,
   output logic [4:0]  id_exccode
);

   logic        fetch_pending;
   logic [31:0] buf_inst;
   logic        buf_held;
   logic        unused_stall;

   assign unused_stall = stall[3] ^ stall[0];

   // A fetch-only stall sends decode a bubble. When decode itself is stalled, every register holds.
   always_ff @(posedge cpu_clk_50M) begin
      if (!cpu_rst_n || flush) begin
         id_pc         <= 32'h0;
         id_valid      <= 1'b0;
         id_in_delay   <= 1'b0;
         id_exccode    <= EXC_NONE;
         fetch_pending <= 1'b0;
      end else begin
         fetch_pending <= if_ice;
         if (stall[STALL_IF] == STOP && stall[STALL_ID] == NOSTOP) begin
            id_pc       <= 32'h0;
            id_valid    <= 1'b0;
            id_in_delay <= 1'b0;
            id_exccode  <= EXC_NONE;
         end else if (stall[STALL_IF] == NOSTOP) begin
            id_pc       <= if_pc;
            id_valid    <= if_ice;
            id_in_delay <= if_branch_flag;
            id_exccode  <= is_misaligned(if_pc[1:0]) ? EXC_ADEL : EXC_NONE;
         end
      end
   end

   ifid_hold_buf u_hold_buf (
      .clk           (cpu_clk_50M),
      .rst_n         (cpu_rst_n),
      .flush         (flush),
      .stall_id      (stall[STALL_ID]),
      .fetch_pending (fetch_pending),
      .inst_i        (inst_i),
      .inst          (buf_inst),
      .held          (buf_held)
   );

   // A misaligned fetch must never reach the decoder, so its word is replaced by a NOP.
   always_comb begin
      id_inst = NOP_INST;
      if (id_exccode != EXC_ADEL && (buf_held || id_valid))
         id_inst = buf_inst;
   end

endmodule

// File: tb/tb_ifid_stage.sv
// Directed bench for ifid_stage. Each step drives one cycle of inputs and then checks the ID outputs.
module tb_ifid_stage;

   logic        cpu_clk_50M = 1'b0;
   logic        cpu_rst_n;
   logic [31:0] if_pc;
   logic        if_ice;
   logic        if_branch_flag;
   logic [31:0] inst_i;
   logic [3:0]  stall;
   logic        flush;
   logic [31:0] id_pc;
   logic [31:0] id_inst;
   logic        id_valid;
   logic        id_in_delay;
   logic [4:0]  id_exccode;

   int passCount  = 0;
   int checkCount = 0;

   always #5 cpu_clk_50M = ~cpu_clk_50M;

   ifid_stage dut (
      .cpu_clk_50M    (cpu_clk_50M),
      .cpu_rst_n      (cpu_rst_n),
      .if_pc          (if_pc),
      .if_ice         (if_ice),
      .if_branch_flag (if_branch_flag),
      .inst_i         (inst_i),
      .stall          (stall),
      .flush          (flush),
      .id_pc          (id_pc),
      .id_inst        (id_inst),
      .id_valid       (id_valid),
      .id_in_delay    (id_in_delay),
      .id_exccode     (id_exccode)
   );

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected)
         passCount++;
      else
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
   endtask

   // Inputs change mid-cycle, away from the rising edge. The ID outputs for this cycle are then checked 1 ns later.
   task automatic applyStimulus(input logic rst_n, input logic [31:0] pc, input logic ice,
                                input logic bflag, input logic [31:0] mem_data,
                                input logic [3:0] stall_v, input logic flush_v);
      @(negedge cpu_clk_50M);
      cpu_rst_n      = rst_n;
      if_pc          = pc;
      if_ice         = ice;
      if_branch_flag = bflag;
      inst_i         = mem_data;
      stall          = stall_v;
      flush          = flush_v;
      #1;
   endtask

   task automatic expectId(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                           input logic valid, input logic in_delay, input logic [4:0] exc);
      checkOutput({tag, ".pc"},    id_pc, pc);
      checkOutput({tag, ".inst"},  id_inst, inst);
      checkOutput({tag, ".valid"}, {31'b0, id_valid}, {31'b0, valid});
      checkOutput({tag, ".delay"}, {31'b0, id_in_delay}, {31'b0, in_delay});
      checkOutput({tag, ".exc"},   {27'b0, id_exccode}, {27'b0, exc});
   endtask

   initial begin
      cpu_rst_n = 1'b0; if_pc = 32'h100; if_ice = 1'b1; if_branch_flag = 1'b0;
      inst_i = 32'hDEAD_BEEF; stall = 4'b0000; flush = 1'b0;

      // Reset held for two cycles; memory data is ignored while nothing is pending.
      applyStimulus(1'b0, 32'h100, 1'b1, 1'b0, 32'hDEAD_BEEF, 4'b0000, 1'b0);
      applyStimulus(1'b0, 32'h100, 1'b1, 1'b0, 32'hDEAD_BEEF, 4'b0000, 1'b0);
      expectId("reset", 32'h0, 32'h0, 1'b0, 1'b0, 5'h10);

      // Streaming fetch; data for PC A arrives one cycle after A is issued.
      applyStimulus(1'b1, 32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF, 4'b0000, 1'b0);
      expectId("post_reset", 32'h0, 32'h0, 1'b0, 1'b0, 5'h10);
      applyStimulus(1'b1, 32'h4, 1'b1, 1'b0, 32'h2408_0001, 4'b0000, 1'b0);
      expectId("stream0", 32'h0, 32'h2408_0001, 1'b1, 1'b0, 5'h10);

      // The ID stall begins in the same cycle that 0x4's data arrives.
      applyStimulus(1'b1, 32'h8, 1'b1, 1'b0, 32'h2409_0002, 4'b0110, 1'b0);
      expectId("stream4", 32'h4, 32'h2409_0002, 1'b1, 1'b0, 5'h10);
      applyStimulus(1'b1, 32'h8, 1'b1, 1'b0, 32'hBAD0_0001, 4'b0110, 1'b0);
      expectId("held1", 32'h4, 32'h2409_0002, 1'b1, 1'b0, 5'h10);
      applyStimulus(1'b1, 32'h8, 1'b1, 1'b0, 32'hBAD0_0002, 4'b0110, 1'b0);
      expectId("held2", 32'h4, 32'h2409_0002, 1'b1, 1'b0, 5'h10);
      applyStimulus(1'b1, 32'h8, 1'b1, 1'b0, 32'hBAD0_0003, 4'b0000, 1'b0);
      expectId("release", 32'h4, 32'h2409_0002, 1'b1, 1'b0, 5'h10);

      // Fetch-only stall in this cycle; it produces one bubble, and then 0xC is refetched.
      applyStimulus(1'b1, 32'hC, 1'b1, 1'b0, 32'h240A_0003, 4'b0010, 1'b0);
      expectId("stream8", 32'h8, 32'h240A_0003, 1'b1, 1'b0, 5'h10);
      applyStimulus(1'b1, 32'hC, 1'b1, 1'b0, 32'h240B_0004, 4'b0000, 1'b0);
      expectId("bubble", 32'h0, 32'h0, 1'b0, 1'b0, 5'h10);
      applyStimulus(1'b1, 32'h10, 1'b1, 1'b1, 32'h240B_0004, 4'b0000, 1'b0);
      expectId("resumeC", 32'hC, 32'h240B_0004, 1'b1, 1'b0, 5'h10);

      // The delay-slot flag follows only the instruction at 0x10.
      applyStimulus(1'b1, 32'h14, 1'b1, 1'b0, 32'h240C_0005, 4'b0000, 1'b0);
      expectId("delay10", 32'h10, 32'h240C_0005, 1'b1, 1'b1, 5'h10);
      applyStimulus(1'b1, 32'h102, 1'b1, 1'b0, 32'h240D_0006, 4'b0000, 1'b0);
      expectId("after14", 32'h14, 32'h240D_0006, 1'b1, 1'b0, 5'h10);
      applyStimulus(1'b1, 32'h18, 1'b1, 1'b0, 32'h1234_5678, 4'b0000, 1'b0);
      expectId("adel", 32'h102, 32'h0, 1'b1, 1'b0, 5'h04);

      // Enter HELD, then flush while still stalled.
      applyStimulus(1'b1, 32'h1C, 1'b1, 1'b0, 32'h240E_0007, 4'b0110, 1'b0);
      expectId("pre_hold", 32'h18, 32'h240E_0007, 1'b1, 1'b0, 5'h10);
      applyStimulus(1'b1, 32'h1C, 1'b1, 1'b0, 32'hBAD0_0004, 4'b0110, 1'b0);
      expectId("held18", 32'h18, 32'h240E_0007, 1'b1, 1'b0, 5'h10);
      applyStimulus(1'b1, 32'h1C, 1'b1, 1'b0, 32'hBAD0_0005, 4'b0110, 1'b1);
      expectId("flush_cyc", 32'h18, 32'h240E_0007, 1'b1, 1'b0, 5'h10);
      applyStimulus(1'b1, 32'h180, 1'b1, 1'b0, 32'hBAD0_0006, 4'b0000, 1'b0);
      expectId("flushed", 32'h0, 32'h0, 1'b0, 1'b0, 5'h10);

      // Handler fetch; then release and re-stall on consecutive cycles to load a fresh hold word.
      applyStimulus(1'b1, 32'h184, 1'b1, 1'b0, 32'h4080_6000, 4'b0110, 1'b0);
      expectId("handler", 32'h180, 32'h4080_6000, 1'b1, 1'b0, 5'h10);
      applyStimulus(1'b1, 32'h184, 1'b1, 1'b0, 32'hBAD0_0007, 4'b0000, 1'b0);
      expectId("rel180", 32'h180, 32'h4080_6000, 1'b1, 1'b0, 5'h10);
      applyStimulus(1'b1, 32'h188, 1'b1, 1'b0, 32'h0000_0025, 4'b0110, 1'b0);
      expectId("run184", 32'h184, 32'h0000_0025, 1'b1, 1'b0, 5'h10);
      applyStimulus(1'b1, 32'h188, 1'b1, 1'b0, 32'hBAD0_0008, 4'b0000, 1'b0);
      expectId("rehold184", 32'h184, 32'h0000_0025, 1'b1, 1'b0, 5'h10);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
